// File: rtl/branch_target_sequencer.sv
// Fetch-PC owner and branch-target generator: resolves execute-stage control
// transfers, loads the branch-address register and bubbles the front end.
module branch_target_sequencer #(
  parameter int unsigned          NrOfBits    = 32,
  parameter logic [NrOfBits-1:0]  ResetVector = '0,
  parameter logic [NrOfBits-1:0]  TrapVector  = 'h4,
  parameter int unsigned          FlushCycles = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                Stall,
  input  logic                ExValid,
  input  logic [NrOfBits-1:0] ExPC,
  input  logic [NrOfBits-1:0] ExImm,
  input  logic [NrOfBits-1:0] ExRs1,
  input  logic                IsBranch,
  input  logic                IsJal,
  input  logic                IsJalr,
  input  logic                CondTrue,
  output logic [NrOfBits-1:0] PC,
  output logic                FetchValid,
  output logic                Flush,
  output logic [NrOfBits-1:0] BranchAddress,
  output logic                BranchAddressLoad,
  output logic                Misaligned,
  output logic [NrOfBits-1:0] LinkAddress
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  localparam logic [NrOfBits-1:0] Four      = NrOfBits'(4);
  localparam logic [3:0]          FlushInit = 4'(FlushCycles - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [NrOfBits-1:0]   pc_q, pc_d;
  logic [NrOfBits-1:0]   ba_q, ba_d;
  logic                  load_q, load_d;
  logic                  mis_q, mis_d;
  logic                  rel_q, rel_d;

  logic                  taken;
  logic [NrOfBits-1:0]   jalr_sum;
  logic [NrOfBits-1:0]   target;

  // Target resolution from execute-stage operands
  assign taken    = ExValid & ((IsBranch & CondTrue) | IsJal | IsJalr);
  assign jalr_sum = ExRs1 + ExImm;
  assign target   = IsJalr ? {jalr_sum[NrOfBits-1:1], 1'b0} : (ExPC + ExImm);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    ba_d    = ba_q;
    load_d  = load_q;
    mis_d   = mis_q;
    rel_d   = rel_q;
    if (Tick) begin
      load_d = 1'b0;
      mis_d  = 1'b0;
      rel_d  = 1'b1;
      unique case (state_q)
        ST_RUN: begin
          // The first Tick after reset release only arms fetch; PC stays on ResetVector.
          if (rel_q) begin
            if (taken) begin
              cnt_d   = FlushInit;
              state_d = ST_REDIRECT;
              if (target[1]) begin
                mis_d = 1'b1;
                pc_d  = TrapVector;
              end else begin
                ba_d   = target;
                load_d = 1'b1;
                pc_d   = target;
              end
            end else if (!Stall) begin
              pc_d = pc_q + Four;
            end
          end
        end
        ST_REDIRECT: begin
          if (cnt_q == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      pc_q    <= ResetVector;
      ba_q    <= '0;
      load_q  <= 1'b0;
      mis_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ba_q    <= ba_d;
      load_q  <= load_d;
      mis_q   <= mis_d;
      rel_q   <= rel_d;
    end
  end

  assign PC                = pc_q;
  assign FetchValid        = (state_q == ST_RUN) & rel_q;
  assign Flush             = (state_q == ST_REDIRECT);
  assign BranchAddress     = ba_q;
  assign BranchAddressLoad = load_q;
  assign Misaligned        = mis_q;
  assign LinkAddress       = ExPC + Four;

endmodule
